// File: rtl/next_pc_stage_pkg.sv
// Shared fetch-unit types: PC width, next-PC state encoding and fetch block size.
package next_pc_stage_pkg;

    typedef logic [31:0] PC_Path;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        STALLED  = 2'd2,
        REDIRECT = 2'd3
    } NextPcState;

    localparam int FETCH_BLOCK_BYTES = 8;

    function automatic PC_Path fetch_block_bytes(input int fetch_width, input int insn_bytes);
        return PC_Path'(fetch_width * insn_bytes);
    endfunction

endpackage

// File: rtl/next_pc_stage_select.sv
// Lowest-lane predicted-taken encoder and target mux.
// RSD_NEXTPC_AX_DECIDER_EN switches the lane condition to the ax/decider flags.
module next_pc_select
    import next_pc_stage_pkg::*;
#(
    parameter int FETCH_WIDTH = 2
) (
    input  logic [FETCH_WIDTH-1:0]       laneValid_i,
    input  logic [FETCH_WIDTH-1:0][31:0] btbOut_i,
    input  logic [FETCH_WIDTH-1:0][31:0] axbtbOut_i,
    input  logic [FETCH_WIDTH-1:0]       btbHit_i,
    input  logic [FETCH_WIDTH-1:0]       brPredTaken_i,
    input  logic [FETCH_WIDTH-1:0]       axbtbHit_i,
    input  logic [FETCH_WIDTH-1:0]       brDecidTaken_i,
    output logic                         taken_o,
    output PC_Path                       target_o
);

    logic [FETCH_WIDTH-1:0] laneTaken;
    PC_Path [FETCH_WIDTH-1:0] laneTarget;

`ifdef RSD_NEXTPC_AX_DECIDER_EN
    logic unused_pred;
    assign unused_pred = ^brPredTaken_i;

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            laneTaken[i]  = laneValid_i[i] & (axbtbHit_i[i] | btbHit_i[i]) & brDecidTaken_i[i];
            laneTarget[i] = axbtbHit_i[i] ? axbtbOut_i[i] : btbOut_i[i];
        end
    end
`else
    logic unused_ax;
    assign unused_ax = ^{axbtbOut_i, axbtbHit_i, brDecidTaken_i};

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            laneTaken[i]  = laneValid_i[i] & btbHit_i[i] & brPredTaken_i[i];
            laneTarget[i] = btbOut_i[i];
        end
    end
`endif

    always_comb begin
        taken_o  = 1'b0;
        target_o = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (!taken_o && laneTaken[i]) begin
                taken_o  = 1'b1;
                target_o = laneTarget[i];
            end
        end
    end

endmodule

// File: rtl/next_pc_stage.sv
// Next-PC generation: PC register, BOOT/RUN/STALLED/REDIRECT control and lane valids.
// Optional macro RSD_NEXTPC_AX_DECIDER_EN selects ax-BTB/decider prediction (see next_pc_select).
module next_pc_stage
    import next_pc_stage_pkg::*;
#(
    parameter int     FETCH_WIDTH  = 2,
    parameter PC_Path RESET_VECTOR = 32'h0000_1000,
    parameter int     INSN_BYTES   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         recover,
    input  logic [31:0]                  recoverPC,
    input  logic [FETCH_WIDTH-1:0]       fetchStageIsValid,
    input  logic [FETCH_WIDTH-1:0][31:0] btbOut,
    input  logic [FETCH_WIDTH-1:0][31:0] axbtbOut,
    input  logic [FETCH_WIDTH-1:0]       btbHit,
    input  logic [FETCH_WIDTH-1:0]       brPredTaken,
    input  logic [FETCH_WIDTH-1:0]       axbtbHit,
    input  logic [FETCH_WIDTH-1:0]       brDecidTaken,
    output logic [31:0]                  fetchPC,
    output logic [FETCH_WIDTH-1:0]       fetchLaneValid
);

    localparam PC_Path BLOCK_BYTES = fetch_block_bytes(FETCH_WIDTH, INSN_BYTES);
    localparam PC_Path INSN_P      = PC_Path'(INSN_BYTES);
    localparam PC_Path FW_P        = PC_Path'(FETCH_WIDTH);

    NextPcState             state_q, state_d;
    PC_Path                 pc_q, pc_d;
    logic [FETCH_WIDTH-1:0] lanes_q, lanes_d;
    logic                   predTaken;
    PC_Path                 predTarget;
    PC_Path                 seqPC;

    // A misaligned entry point leaves the lanes below the entry slot empty.
    function automatic logic [FETCH_WIDTH-1:0] lane_mask(input PC_Path pc);
        PC_Path first;
        first = (pc / INSN_P) % FW_P;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_mask[i] = (PC_Path'(i) >= first);
        end
    endfunction

    next_pc_select #(
        .FETCH_WIDTH(FETCH_WIDTH)
    ) u_select (
        .laneValid_i   (fetchStageIsValid),
        .btbOut_i      (btbOut),
        .axbtbOut_i    (axbtbOut),
        .btbHit_i      (btbHit),
        .brPredTaken_i (brPredTaken),
        .axbtbHit_i    (axbtbHit),
        .brDecidTaken_i(brDecidTaken),
        .taken_o       (predTaken),
        .target_o      (predTarget)
    );

    assign seqPC = pc_q - (pc_q % BLOCK_BYTES) + BLOCK_BYTES;

    // Leaving BOOT or REDIRECT keeps the PC so the entry block is actually fetched.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lanes_d = lanes_q;
        if (recover) begin
            state_d = REDIRECT;
            pc_d    = recoverPC;
            lanes_d = '0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                    lanes_d = lane_mask(pc_q);
                end
                REDIRECT: begin
                    state_d = stall ? STALLED : RUN;
                    lanes_d = lane_mask(pc_q);
                end
                RUN, STALLED: begin
                    if (stall) begin
                        state_d = STALLED;
                    end else begin
                        state_d = RUN;
                        pc_d    = predTaken ? predTarget : seqPC;
                        lanes_d = lane_mask(pc_d);
                    end
                end
                default: begin
                    state_d = BOOT;
                    pc_d    = RESET_VECTOR;
                    lanes_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lanes_q <= lanes_d;
        end
    end

    assign fetchPC        = pc_q;
    assign fetchLaneValid = lanes_q;

endmodule

// File: tb/tb_next_pc_stage.sv
// Directed bench for next_pc_stage with a cycle-level reference model and literal checkpoints.
module tb_next_pc_stage;

    localparam int          FW = 2;
    localparam int          IB = 4;
    localparam logic [31:0] RV = 32'h0000_1000;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                stall = 1'b0;
    logic                recover = 1'b0;
    logic [31:0]         recoverPC = '0;
    logic [FW-1:0]       fsv = 2'b11;
    logic [FW-1:0][31:0] btbOut = '0;
    logic [FW-1:0][31:0] axbtbOut = '0;
    logic [FW-1:0]       btbHit = '0;
    logic [FW-1:0]       brPredTaken = '0;
    logic [FW-1:0]       axbtbHit = '0;
    logic [FW-1:0]       brDecidTaken = '0;
    logic [31:0]         fetchPC;
    logic [FW-1:0]       fetchLaneValid;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    next_pc_stage #(
        .FETCH_WIDTH (FW),
        .RESET_VECTOR(RV),
        .INSN_BYTES  (IB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .recover          (recover),
        .recoverPC        (recoverPC),
        .fetchStageIsValid(fsv),
        .btbOut           (btbOut),
        .axbtbOut         (axbtbOut),
        .btbHit           (btbHit),
        .brPredTaken      (brPredTaken),
        .axbtbHit         (axbtbHit),
        .brDecidTaken     (brDecidTaken),
        .fetchPC          (fetchPC),
        .fetchLaneValid   (fetchLaneValid)
    );

    // Reference model: a PC plus a flag saying whether the front end is delivering
    // instructions (false right after reset or a redirect, for exactly one edge).
    logic [31:0] m_pc;
    logic        m_fetching;

    function automatic logic [31:0] m_advance(input logic [31:0] pc);
        logic [31:0] nxt;
        nxt = (pc / 32'(FW * IB)) * 32'(FW * IB) + 32'(FW * IB);
        for (int i = FW - 1; i >= 0; i--) begin
`ifdef RSD_NEXTPC_AX_DECIDER_EN
            if (fsv[i] && (axbtbHit[i] || btbHit[i]) && brDecidTaken[i])
                nxt = axbtbHit[i] ? axbtbOut[i] : btbOut[i];
`else
            if (fsv[i] && btbHit[i] && brPredTaken[i])
                nxt = btbOut[i];
`endif
        end
        return nxt;
    endfunction

    function automatic logic [FW-1:0] m_lanes(input logic [31:0] pc, input logic fetching);
        logic [FW-1:0] l;
        for (int i = 0; i < FW; i++) begin
            l[i] = fetching && (i >= int'((pc / IB) % FW));
        end
        return l;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc       <= RV;
            m_fetching <= 1'b0;
        end else if (recover) begin
            m_pc       <= recoverPC;
            m_fetching <= 1'b0;
        end else if (!m_fetching) begin
            m_fetching <= 1'b1;
        end else if (!stall) begin
            m_pc <= m_advance(m_pc);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            n_vec++;
            if (fetchPC !== m_pc || fetchLaneValid !== m_lanes(m_pc, m_fetching)) begin
                n_bad++;
                $display("FAIL model t=%0t: pc=%h lanes=%b, expected pc=%h lanes=%b",
                         $time, fetchPC, fetchLaneValid, m_pc, m_lanes(m_pc, m_fetching));
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] pc_exp, input logic [FW-1:0] ln_exp);
        n_vec++;
        if (fetchPC !== pc_exp || fetchLaneValid !== ln_exp) begin
            n_bad++;
            $display("FAIL %s: pc=%h lanes=%b, expected pc=%h lanes=%b",
                     name, fetchPC, fetchLaneValid, pc_exp, ln_exp);
        end
    endtask

    task automatic chk_pc(input string name, input logic [31:0] pc_exp);
        n_vec++;
        if (fetchPC !== pc_exp) begin
            n_bad++;
            $display("FAIL %s: pc=%h, expected pc=%h", name, fetchPC, pc_exp);
        end
    endtask

    initial begin
        repeat (3) cyc();
        chk("reset_state", 32'h1000, 2'b00);

        rst = 1'b1;
        chk("boot_cycle1", 32'h1000, 2'b00);
        cyc(); chk("boot_cycle2", 32'h1000, 2'b11);
        cyc(); chk("seq_1008", 32'h1008, 2'b11);
        cyc(); chk("seq_1010", 32'h1010, 2'b11);

        stall = 1'b1;
        repeat (3) begin
            cyc(); chk("stall_hold", 32'h1010, 2'b11);
        end
        stall = 1'b0;
        cyc(); chk("stall_release", 32'h1018, 2'b11);

        stall = 1'b1; btbHit = 2'b11; brPredTaken = 2'b11;
        btbOut[0] = 32'h7100; btbOut[1] = 32'h7000;
        cyc(); chk("pred_ignored_in_stall", 32'h1018, 2'b11);
        stall = 1'b0;
        cyc(); chk("lowest_lane_wins", 32'h7100, 2'b11);
        btbHit = 2'b00; brPredTaken = 2'b00;
        cyc(); chk("seq_after_taken", 32'h7108, 2'b11);

        recover = 1'b1; recoverPC = 32'h2000;
        cyc(); chk("redirect_bubble", 32'h2000, 2'b00);
        recover = 1'b0;
        cyc(); chk("after_bubble", 32'h2000, 2'b11);
        btbHit = 2'b10; brPredTaken = 2'b10; btbOut[1] = 32'h3004;
        cyc(); chk("taken_lane1_masked", 32'h3004, 2'b10);
        btbHit = 2'b00; brPredTaken = 2'b00;
        cyc(); chk("seq_3008", 32'h3008, 2'b11);

        fsv = 2'b10; btbHit = 2'b11; brPredTaken = 2'b11;
        btbOut[0] = 32'h8000; btbOut[1] = 32'h9000;
        cyc(); chk("invalid_lane_ignored", 32'h9000, 2'b11);
        fsv = 2'b11; btbHit = 2'b00; brPredTaken = 2'b00;
        cyc(); chk("seq_9008", 32'h9008, 2'b11);

        axbtbHit = 2'b01; brDecidTaken = 2'b01; btbHit = 2'b01;
        axbtbOut[0] = 32'h5000; btbOut[0] = 32'h6000;
        cyc();
`ifdef RSD_NEXTPC_AX_DECIDER_EN
        chk("ax_decider_taken", 32'h5000, 2'b11);
`else
        chk("ax_inputs_unused", 32'h9010, 2'b11);
`endif
        axbtbHit = 2'b00; brDecidTaken = 2'b00; btbHit = 2'b00;

        recover = 1'b1; recoverPC = 32'h4000; stall = 1'b1;
        cyc(); chk("recover_with_stall", 32'h4000, 2'b00);
        recover = 1'b0;
        cyc(); chk_pc("stalled_after_redirect", 32'h4000);
        cyc(); chk_pc("stalled_after_redirect2", 32'h4000);
        stall = 1'b0;
        cyc(); chk("stall_drop_after_redirect", 32'h4008, 2'b11);

        recover = 1'b1; recoverPC = 32'h5000;
        cyc(); chk("redirect_first", 32'h5000, 2'b00);
        recoverPC = 32'h5104;
        cyc(); chk("redirect_extended", 32'h5104, 2'b00);
        recover = 1'b0;
        cyc(); chk("misaligned_entry", 32'h5104, 2'b10);
        cyc(); chk("seq_5108", 32'h5108, 2'b11);

        recover = 1'b1; recoverPC = 32'hFFFF_FFF8;
        cyc(); recover = 1'b0;
        cyc(); chk("top_of_space", 32'hFFFF_FFF8, 2'b11);
        cyc(); chk("wrap_to_zero", 32'h0000_0000, 2'b11);

        stall = 1'b1;
        cyc(); chk("stall_at_zero", 32'h0000_0000, 2'b11);
        recover = 1'b1; recoverPC = 32'hA000;
        cyc(); chk("recover_from_stalled", 32'hA000, 2'b00);
        recover = 1'b0; stall = 1'b0;
        cyc(); chk("run_after_recover", 32'hA000, 2'b11);

        stall = 1'b1; recover = 1'b1; recoverPC = 32'hB000;
        rst = 1'b0;
        #1; chk("async_reset", 32'h1000, 2'b00);
        cyc(); chk("reset_held", 32'h1000, 2'b00);
        stall = 1'b0; recover = 1'b0;
        rst = 1'b1;
        chk("reboot_cycle1", 32'h1000, 2'b00);
        cyc(); chk("reboot_cycle2", 32'h1000, 2'b11);
        cyc(); chk("reboot_cycle3", 32'h1008, 2'b11);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
